// File: rtl/subservient_gpio_bank_if.sv
// rtl/subservient_gpio_bank_if.sv - Wishbone data-bus bundle for the GPIO bank
interface subservient_gpio_bank_if;
    logic [2:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/subservient_gpio_bank.sv
// rtl/subservient_gpio_bank.sv - WIDTH-pin GPIO bank on Wishbone
// Edge interrupts (RISE_EN/FALL_EN/PEND, o_irq) exist only with SUBSERVIENT_GPIO_IRQ_EN defined.
module subservient_gpio_bank #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    subservient_gpio_bank_if.slave wb,
    input  logic [WIDTH-1:0]     i_gpio,
    output logic [WIDTH-1:0]     o_gpio,
    output logic [WIDTH-1:0]     o_gpio_oe,
    output logic                 o_irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic             ack_q, ack_d;
    logic [31:0]      rdt_q, rdt_d;
    logic [31:0]      rd_data;
    logic             access;
    logic             wr_en;
    logic             unused_dat;

`ifdef SUBSERVIENT_GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] clr;
`endif

    // An access is taken only when ack is low, which forces a gap cycle between acks.
    assign access     = wb.i_wb_stb & ~ack_q;
    assign wr_en      = access & wb.i_wb_we;
    assign unused_dat = ^wb.i_wb_dat;

    always_comb begin
        rd_data = '0;
        case (wb.i_wb_adr)
            3'd0: rd_data[WIDTH-1:0] = out_q;
            3'd1: rd_data[WIDTH-1:0] = oe_q;
            3'd2: rd_data[WIDTH-1:0] = sync2_q;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            3'd3: rd_data[WIDTH-1:0] = rise_en_q;
            3'd4: rd_data[WIDTH-1:0] = fall_en_q;
            3'd5: rd_data[WIDTH-1:0] = pend_q;
`endif
            default: ;
        endcase

        out_d = out_q;
        oe_d  = oe_q;
        if (wr_en && wb.i_wb_adr == 3'd0) out_d = wb.i_wb_dat[WIDTH-1:0];
        if (wr_en && wb.i_wb_adr == 3'd1) oe_d  = wb.i_wb_dat[WIDTH-1:0];

        ack_d = access;
        rdt_d = access ? rd_data : 32'd0;

`ifdef SUBSERVIENT_GPIO_IRQ_EN
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr_en && wb.i_wb_adr == 3'd3) rise_en_d = wb.i_wb_dat[WIDTH-1:0];
        if (wr_en && wb.i_wb_adr == 3'd4) fall_en_d = wb.i_wb_dat[WIDTH-1:0];

        clr = (wr_en && wb.i_wb_adr == 3'd5) ? wb.i_wb_dat[WIDTH-1:0] : '0;
        // Set terms are OR-ed after the clear so a coincident edge wins.
        pend_d = (pend_q & ~clr)
               | (sync2_q & ~prev_q & rise_en_q)
               | (~sync2_q & prev_q & fall_en_q);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            ack_q     <= 1'b0;
            rdt_q     <= 32'd0;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            prev_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
`endif
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            sync1_q   <= i_gpio;
            sync2_q   <= sync1_q;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            prev_q    <= sync2_q;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
`endif
        end
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_rdt = rdt_q;
    assign o_gpio      = out_q;
    assign o_gpio_oe   = oe_q;

`ifdef SUBSERVIENT_GPIO_IRQ_EN
    assign o_irq = |pend_q;
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_subservient_gpio_bank.sv
// tb/tb_subservient_gpio_bank.sv - self-checking bench for subservient_gpio_bank
module tb_subservient_gpio_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out, gpio_oe;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit ready    = 1'b0;

    subservient_gpio_bank_if bus ();

    subservient_gpio_bank #(.WIDTH(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .wb        (bus),
        .i_gpio    (gpio_in),
        .o_gpio    (gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register values plus a history of pin samples taken at each edge.
    // hist[k] is the pin value sampled k+1 edges before the current one.
    logic [7:0]  m_out, m_oe, m_ren, m_fen, m_pend;
    logic [7:0]  hist [3];
    logic        m_ack;
    logic [31:0] m_rdt;
    logic        m_acc;
    logic [7:0]  m_clr, m_rise, m_fall;

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_out;
            3'd1: return m_oe;
            3'd2: return hist[1];
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            3'd3: return m_ren;
            3'd4: return m_fen;
            3'd5: return m_pend;
`endif
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_out = 0; m_oe = 0; m_ren = 0; m_fen = 0; m_pend = 0;
            m_ack = 0; m_rdt = 0;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
        end else begin
            m_acc = bus.i_wb_stb && !m_ack;
            m_rdt = m_acc ? {24'h0, m_read(bus.i_wb_adr)} : 32'h0;
            m_ack = m_acc;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            m_rise = hist[1] & ~hist[2];
            m_fall = ~hist[1] & hist[2];
            m_clr  = (m_acc && bus.i_wb_we && bus.i_wb_adr == 3'd5) ? bus.i_wb_dat[7:0] : 8'h00;
            m_pend = (m_pend & ~m_clr) | (m_rise & m_ren) | (m_fall & m_fen);
            if (m_acc && bus.i_wb_we && bus.i_wb_adr == 3'd3) m_ren = bus.i_wb_dat[7:0];
            if (m_acc && bus.i_wb_we && bus.i_wb_adr == 3'd4) m_fen = bus.i_wb_dat[7:0];
`endif
            if (m_acc && bus.i_wb_we && bus.i_wb_adr == 3'd0) m_out = bus.i_wb_dat[7:0];
            if (m_acc && bus.i_wb_we && bus.i_wb_adr == 3'd1) m_oe  = bus.i_wb_dat[7:0];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = gpio_in;
        end
    end

    always @(negedge clk) begin
        if (ready) begin
            check("o_gpio",    {24'h0, gpio_out}, {24'h0, m_out});
            check("o_gpio_oe", {24'h0, gpio_oe},  {24'h0, m_oe});
            check("o_irq",     {31'h0, irq},      {31'h0, |m_pend});
            check("o_wb_ack",  {31'h0, bus.o_wb_ack}, {31'h0, m_ack});
            check("o_wb_rdt",  bus.o_wb_rdt, m_rdt);
        end
    end

    // Called at a negedge; returns at a negedge with stb low.
    task automatic wb_xfer(input logic [2:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rdt);
        bit got = 0;
        bus.i_wb_adr = a; bus.i_wb_we = we; bus.i_wb_dat = d; bus.i_wb_stb = 1'b1;
        rdt = 32'hDEAD_BEEF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.o_wb_ack) begin
                got = 1;
                rdt = bus.o_wb_rdt;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout: no ack for adr %0d within 8 cycles", a);
        end
        @(negedge clk);
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(a, 1'b0, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(a, 1'b1, d, r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] held_rdt [3];
    int          held_acks;

    initial begin
        bus.i_wb_adr = 0; bus.i_wb_dat = 0; bus.i_wb_we = 0; bus.i_wb_stb = 0;
        repeat (3) @(posedge clk);
        ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_gpio", {24'h0, gpio_out}, 32'h0);
        check("reset_oe",   {24'h0, gpio_oe},  32'h0);
        check("reset_irq",  {31'h0, irq},      32'h0);
        check("reset_ack",  {31'h0, bus.o_wb_ack}, 32'h0);

        rd_expect("rd_out_rst",  3'd0, 32'h0);
        rd_expect("rd_oe_rst",   3'd1, 32'h0);
        rd_expect("rd_in_rst",   3'd2, 32'h0);
        rd_expect("rd_pend_rst", 3'd5, 32'h0);

        wr(3'd0, 32'h0000_01A5);
        check("pins_out", {24'h0, gpio_out}, 32'hA5);
        wr(3'd1, 32'h0000_00F0);
        check("pins_oe", {24'h0, gpio_oe}, 32'hF0);
        rd_expect("rd_out", 3'd0, 32'h0000_00A5);
        rd_expect("rd_oe",  3'd1, 32'h0000_00F0);

        // Pin change lands at the same edge as the first of three held-stb reads.
        gpio_in = 8'h3C;
        bus.i_wb_adr = 3'd2; bus.i_wb_we = 1'b0; bus.i_wb_stb = 1'b1;
        held_acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.o_wb_ack) begin
                if (held_acks < 3) held_rdt[held_acks] = bus.o_wb_rdt;
                held_acks++;
            end
        end
        @(negedge clk);
        bus.i_wb_stb = 1'b0;
        check("held_ack_count", held_acks, 3);
        check("in_edge_N",   held_rdt[0], 32'h00);
        check("in_edge_N+2", held_rdt[1], 32'h3C);

        wr(3'd2, 32'hFF);
        rd_expect("in_write_ignored", 3'd2, 32'h3C);
        wr(3'd6, 32'hFF);
        rd_expect("rsvd6", 3'd6, 32'h0);
        rd_expect("rsvd7", 3'd7, 32'h0);

`ifdef SUBSERVIENT_GPIO_IRQ_EN
        wr(3'd3, 32'h01);
        wr(3'd4, 32'h02);
        gpio_in = 8'h3E; idle(4);
        rd_expect("pend_rise_disabled", 3'd5, 32'h00);
        gpio_in = 8'h3F; idle(4);
        gpio_in = 8'h3D; idle(4);
        rd_expect("pend_both", 3'd5, 32'h03);
        check("irq_set", {31'h0, irq}, 32'h1);
        wr(3'd5, 32'h01);
        rd_expect("pend_clr0", 3'd5, 32'h02);
        wr(3'd5, 32'h02);
        check("irq_clr", {31'h0, irq}, 32'h0);
        gpio_in = 8'h3C; idle(4);
        gpio_in = 8'h3D;
        idle(2);
        wr(3'd5, 32'h01);
        rd_expect("set_wins", 3'd5, 32'h01);
        wr(3'd3, 32'h00);
        rd_expect("disable_keeps", 3'd5, 32'h01);
        wr(3'd5, 32'hFF);
        check("irq_final", {31'h0, irq}, 32'h0);
`else
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'hFF);
        gpio_in = 8'h00; idle(4);
        gpio_in = 8'hFF; idle(4);
        rd_expect("noirq_rise_en", 3'd3, 32'h0);
        rd_expect("noirq_fall_en", 3'd4, 32'h0);
        rd_expect("noirq_pend",    3'd5, 32'h0);
        check("noirq_irq", {31'h0, irq}, 32'h0);
`endif

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subservient_gpio_bank.md
# subservient_gpio_bank

Parametrised multi-bit GPIO peripheral for the subservient SoC, the successor of the single-bit GPIO. It sits on the core's Wishbone data bus and provides WIDTH pins with per-pin output data, output enable, two-flop synchronised inputs and, optionally, per-pin rising/falling-edge interrupts with write-1-to-clear pending bits. It acknowledges every access with a registered single-cycle ack.

## Interface
- WIDTH, 8, number of GPIO pins; legal range 1..32
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wb_adr  in  3  register word select (byte address bits [4:2])
- i_wb_dat  in  32  write data; bits [31:WIDTH] ignored
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_stb  in  1  access request; held high until ack
- o_wb_rdt  out  32  read data, valid while o_wb_ack high; bits [31:WIDTH] always 0
- o_wb_ack  out  1  single-cycle acknowledge
- i_gpio  in  WIDTH  asynchronous pin inputs
- o_gpio  out  WIDTH  pin output data
- o_gpio_oe  out  WIDTH  per-pin output enable (1 = drive)
- o_irq  out  1  interrupt request, OR of all pending bits

## Operation
- Register map (i_wb_adr): 0 OUT (RW), 1 OE (RW), 2 IN (RO, synchronised pin value), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 PEND (read; write-1-to-clear), 6-7 reserved: reads 0, writes ignored. Writes to IN ignored.
- o_gpio = OUT, o_gpio_oe = OE, driven directly from registers.
- Input path: sync1 <= i_gpio; sync2 <= sync1; prev <= sync2. IN reads sync2.
- Edge detect per pin: rise = sync2 & ~prev; fall = ~sync2 & prev.
- PEND next = (PEND & ~clr) | (rise & RISE_EN) | (fall & FALL_EN), where clr = i_wb_dat[WIDTH-1:0] when a PEND write is acknowledged, else 0. A new edge in the same cycle as its clear sets the bit (set wins).
- Disabling an enable does not clear already-pending bits.
- o_irq = |PEND (combinational OR of registers only).

## Timing
- Reset (edge with i_rst=1): OUT, OE, RISE_EN, FALL_EN, PEND, sync1, sync2, prev, o_wb_ack, o_wb_rdt all 0; hence o_gpio=0, o_gpio_oe=0, o_irq=0.
- A pin high across reset release produces a rise on sync2 about 2 cycles later; it sets PEND only if RISE_EN was written first (it is 0 out of reset).
- o_wb_ack <= i_wb_stb & ~o_wb_ack. stb sampled high at edge N gives ack high during cycle N..N+1, low the next cycle even if stb stays high: minimum two cycles per access, no back-to-back acks.
- Write commits on the same edge that raises ack; the new OUT/OE value is on the pins the cycle ack is high.
- o_wb_rdt is registered on the edge that raises ack, from register contents before that edge; 0 when not acking.
- Input latency: i_gpio change before edge N is visible in IN after edge N+1; PEND bit sets at edge N+2; o_irq follows in the same cycle.
- i_rst asserted mid-access: ack and rdt are cleared at that edge, and a write sampled at that edge is discarded.

## Configuration
- SUBSERVIENT_GPIO_IRQ_EN defined: RISE_EN, FALL_EN and PEND registers, prev flops, edge logic and o_irq are implemented as described.
- Not defined: none of these are implemented; addresses 3-5 read 0 and ignore writes; o_irq tied 0; OUT, OE, IN and the bus timing are unchanged.

## Test plan
- Reset, then read addr 0,1,2,5 with i_gpio=0 -> all rdt 0, o_gpio=0, o_gpio_oe=0, o_irq=0, one ack per access.
- WIDTH=8: write OUT=0x1A5, then OE=0xF0 -> o_gpio=0xA5, o_gpio_oe=0xF0; readback 0xA5 and 0xF0; rdt[31:8]=0.
- i_gpio 0x00->0x3C at edge N -> IN read returns 0x3C when sampled from edge N+2; ack never high on two consecutive cycles with stb held.
- Write RISE_EN=0x01, FALL_EN=0x02; raise i_gpio[0], then lower i_gpio[1] (previously high) -> PEND=0x03, o_irq=1; write PEND=0x01 -> PEND=0x02; write 0x02 -> o_irq=0.
- Rising edge on pin 0 landing on the same edge as a PEND write of 0x01 -> PEND[0] stays 1.
- Build without SUBSERVIENT_GPIO_IRQ_EN and apply edges after writing 0xFF to addr 3 -> addr 3/4/5 read 0 and o_irq stays 0.
